// File: rtl/rni_rx_lcrd_ctrl.sv
// RX-channel L-credit controller: issues RXLCRDV in RUN, reclaims credits on drain/return, strips credit-return flits.
// Optional credit-protocol error checking with saturating counters is enabled by defining RNI_LCRD_ERR_CHK_EN.
module rni_rx_lcrd_ctrl #(
  parameter int FLIT_WIDTH     = 128,
  parameter int OPCODE_LSB     = 0,
  parameter int OPCODE_WIDTH   = 4,
  parameter int CRD_MAX        = 15,
  parameter int CRD_CNT_WIDTH  = 4,
  parameter int LL_STATE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LL_STATE_WIDTH-1:0] rxlink_state,
  input  logic                      rxcrd_en,
  input  logic                      RXFLITV,
  input  logic [FLIT_WIDTH-1:0]     RXFLIT,
  input  logic                      rxbuf_release,
  output logic                      RXLCRDV,
  output logic                      rxcrd_cnt_full,
  output logic                      rxflit_vld,
  output logic [FLIT_WIDTH-1:0]     rxflit
`ifdef RNI_LCRD_ERR_CHK_EN
  ,
  output logic                      lcrd_err
`endif
);

  localparam logic [LL_STATE_WIDTH-1:0] LL_STOP   = {LL_STATE_WIDTH{1'b0}};
  localparam logic [CRD_CNT_WIDTH-1:0]  CRD_MAX_C = CRD_CNT_WIDTH'(CRD_MAX);
  localparam logic [CRD_CNT_WIDTH-1:0]  CNT_ZERO  = {CRD_CNT_WIDTH{1'b0}};
  localparam logic [CRD_CNT_WIDTH-1:0]  CNT_ONE   = {{(CRD_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CRD_CNT_WIDTH-1:0] avail_r;
  logic [CRD_CNT_WIDTH-1:0] out_r;
  logic [CRD_CNT_WIDTH-1:0] avail_nxt_s;
  logic [CRD_CNT_WIDTH-1:0] out_nxt_s;
  logic                     stop_s;
  logic                     flit_s;
  logic                     ret_s;
  logic                     fwd_s;
  logic                     issue_s;

  // Classify this cycle's events: credit issue, credit-return flit, protocol flit.
  always_comb begin
    stop_s  = (rxlink_state == LL_STOP);
    flit_s  = RXFLITV & ~stop_s;
    ret_s   = flit_s & (RXFLIT[OPCODE_LSB +: OPCODE_WIDTH] == {OPCODE_WIDTH{1'b0}});
    fwd_s   = flit_s & ~ret_s;
    issue_s = rxcrd_en & (avail_r != CNT_ZERO);
  end

`ifdef RNI_LCRD_ERR_CHK_EN
  localparam int               SW        = CRD_CNT_WIDTH + 2;
  localparam logic [SW-1:0]    CRD_MAX_W = SW'(CRD_MAX);
  localparam logic [SW-1:0]    SW_ONE    = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    SW_ZERO   = {SW{1'b0}};

  logic [SW-1:0] avail_sum_s;
  logic [SW-1:0] out_sum_s;
  logic          out_under_s;
  logic          avail_over_s;
  logic          err_set_s;
  logic          lcrd_err_r;

  // Widened single-sum update so overflow/underflow is visible; counters saturate instead of wrapping.
  always_comb begin
    avail_sum_s = {2'b00, avail_r}
                + (ret_s ? SW_ONE : SW_ZERO)
                + (rxbuf_release ? SW_ONE : SW_ZERO)
                - (issue_s ? SW_ONE : SW_ZERO);
    out_sum_s   = {2'b00, out_r}
                + (issue_s ? SW_ONE : SW_ZERO)
                - (flit_s ? SW_ONE : SW_ZERO);
    out_under_s  = out_sum_s[SW-1];
    avail_over_s = (avail_sum_s > CRD_MAX_W);
    if (avail_over_s) begin
      avail_nxt_s = CRD_MAX_C;
    end else begin
      avail_nxt_s = avail_sum_s[CRD_CNT_WIDTH-1:0];
    end
    if (out_under_s) begin
      out_nxt_s = CNT_ZERO;
    end else if (out_sum_s > CRD_MAX_W) begin
      out_nxt_s = CRD_MAX_C;
    end else begin
      out_nxt_s = out_sum_s[CRD_CNT_WIDTH-1:0];
    end
    err_set_s = (RXFLITV & stop_s)
              | (flit_s & (out_r == CNT_ZERO))
              | avail_over_s;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcrd_err_r <= 1'b0;
    end else if (err_set_s) begin
      lcrd_err_r <= 1'b1;
    end
  end

  assign lcrd_err = lcrd_err_r;
`else
  // Plain modulo counter update; no overflow detection in this build.
  always_comb begin
    avail_nxt_s = avail_r
                + (ret_s ? CNT_ONE : CNT_ZERO)
                + (rxbuf_release ? CNT_ONE : CNT_ZERO)
                - (issue_s ? CNT_ONE : CNT_ZERO);
    out_nxt_s   = out_r
                + (issue_s ? CNT_ONE : CNT_ZERO)
                - (flit_s ? CNT_ONE : CNT_ZERO);
  end
`endif

  // Credit counters: held-locally and outstanding-at-peer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail_r <= CRD_MAX_C;
      out_r   <= CNT_ZERO;
    end else begin
      avail_r <= avail_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  // Registered credit and forwarded-flit outputs; payload holds when no protocol flit arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RXLCRDV    <= 1'b0;
      rxflit_vld <= 1'b0;
      rxflit     <= {FLIT_WIDTH{1'b0}};
    end else begin
      RXLCRDV    <= issue_s;
      rxflit_vld <= fwd_s;
      if (fwd_s) begin
        rxflit <= RXFLIT;
      end
    end
  end

  assign rxcrd_cnt_full = (avail_r == CRD_MAX_C);

endmodule
